// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned subtractor, LSB first, one bit per clock
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             d_bit,
    output logic             d_valid
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, w_q, w_d, diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             bw_q, bw_d, borrow_q, borrow_d;
    logic             d, bw_n;

    // full-subtractor cell on the current operand LSBs and the running borrow
    always_comb begin
        d    = a_q[0] ^ b_q[0] ^ bw_q;
        bw_n = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & bw_q);
    end

    // next-state: launch in IDLE, shift one bit per cycle, publish result on the last bit
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        w_d      = w_q;
        cnt_d    = cnt_q;
        bw_d     = bw_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    bw_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                w_d   = {d, w_q[WIDTH-1:1]};
                bw_d  = bw_n;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    diff_d   = w_d;
                    borrow_d = bw_n;
                    state_d  = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // state registers; reset overrides any launch or in-flight operation
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            w_q      <= '0;
            cnt_q    <= '0;
            bw_q     <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            w_q      <= w_d;
            cnt_q    <= cnt_d;
            bw_q     <= bw_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
        end
    end

    assign busy    = state_q != IDLE;
    assign done    = state_q == DONE;
    assign d_valid = state_q == SHIFT;
    assign d_bit   = d_valid & d;
    assign diff    = diff_q;
    assign borrow  = borrow_q;
endmodule
